// File: rtl/arbitro_comparador_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : arbitro_comparador_pkg
//  Purpose : Shared constants and types for the date-comparison arbiter:
//            verdict codes, FSM state encoding and date field widths/limits.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package arbitro_comparador_pkg;

   localparam int DIA_W = 5;
   localparam int MES_W = 4;

   localparam logic [DIA_W-1:0] DIA_MAX = 5'd31;
   localparam logic [MES_W-1:0] MES_MAX = 4'd12;

   typedef logic [1:0] verdict_t;

   localparam verdict_t V_MENOR    = 2'b00;
   localparam verdict_t V_IGUAL    = 2'b01;
   localparam verdict_t V_MAYOR    = 2'b10;
   localparam verdict_t V_INVALIDO = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COMP = 2'd1,
      RESP = 2'd2
   } state_t;

   // A date is usable when both fields are inside their calendar range.
   // Day-per-month limits are intentionally not checked.
   function automatic logic fecha_valida(input logic [DIA_W-1:0] dia,
                                         input logic [MES_W-1:0] mes);
      return (dia != '0) && (dia <= DIA_MAX) && (mes != '0) && (mes <= MES_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_fecha_unit.sv
`default_nettype none
// ============================================================================
//  Module  : comparador_fecha_unit
//  Purpose : Purely combinational comparison of a dia/mes date against a
//            reference date. Month is compared first, day breaks ties.
//  Ports   : i_dia, i_mes         date under test
//            i_dia_ref, i_mes_ref reference date
//            o_v                  verdict (menor/igual/mayor/invalido)
//  Rev     : 1.0  initial release
// ============================================================================
module comparador_fecha_unit
   import arbitro_comparador_pkg::*;
(
   input  logic [DIA_W-1:0] i_dia,
   input  logic [MES_W-1:0] i_mes,
   input  logic [DIA_W-1:0] i_dia_ref,
   input  logic [MES_W-1:0] i_mes_ref,
   output verdict_t         o_v
);

   always_comb begin
      o_v = V_INVALIDO;
      if (fecha_valida(i_dia, i_mes) && fecha_valida(i_dia_ref, i_mes_ref)) begin
         if (i_mes < i_mes_ref)       o_v = V_MENOR;
         else if (i_mes > i_mes_ref)  o_v = V_MAYOR;
         else if (i_dia < i_dia_ref)  o_v = V_MENOR;
         else if (i_dia > i_dia_ref)  o_v = V_MAYOR;
         else                         o_v = V_IGUAL;
      end
   end

endmodule
`default_nettype wire

// File: rtl/arbitro_comparador_fechas.sv
`default_nettype none
// ============================================================================
//  Module  : arbitro_comparador_fechas
//  Purpose : Round-robin arbiter sharing one date comparator among N_REQ
//            requesters. Each granted request is compared against a
//            programmable reference date; the verdict is returned tagged
//            with the requester ID over a valid/ready channel.
//  Ports   : clk, reset (sync, active-high)
//            ref_we/ref_dia/ref_mes      reference date load
//            req_valid/req_dia/req_mes   packed per-requester requests
//            req_ready                   one-hot combinational accept
//            resp_valid/resp_ready/resp_id/resp_V  verdict channel
//            busy                        FSM not idle
//            cnt_menor/igual/mayor/invalido (only with ARBITRO_COMP_STATS_EN)
//  Config  : define ARBITRO_COMP_STATS_EN to add saturating verdict counters.
//  Rev     : 1.0  initial release
// ============================================================================
module arbitro_comparador_fechas
   import arbitro_comparador_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ref_we,
   input  logic [DIA_W-1:0]       ref_dia,
   input  logic [MES_W-1:0]       ref_mes,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [DIA_W*N_REQ-1:0] req_dia,
   input  logic [MES_W*N_REQ-1:0] req_mes,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output verdict_t               resp_V,
   output logic                   busy
`ifdef ARBITRO_COMP_STATS_EN
   ,
   output logic [15:0]            cnt_menor,
   output logic [15:0]            cnt_igual,
   output logic [15:0]            cnt_mayor,
   output logic [15:0]            cnt_invalido
`endif
);

   state_t           r_state;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  r_id;
   logic [DIA_W-1:0] r_dia;
   logic [MES_W-1:0] r_mes;
   logic [DIA_W-1:0] r_ref_dia;
   logic [MES_W-1:0] r_ref_mes;

   logic             w_gnt_any;
   logic [ID_W-1:0]  w_gnt_id;
   logic [DIA_W-1:0] w_sel_dia;
   logic [MES_W-1:0] w_sel_mes;
   verdict_t         w_v;

   // Search from rr_ptr upward (mod N_REQ). The loop runs from the farthest
   // offset down so the nearest asserted requester is the last to win.
   always_comb begin : p_arb
      logic [ID_W-1:0] v_idx;
      v_idx     = '0;
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         v_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
         if (req_valid[v_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = v_idx;
         end
      end
   end

   // Operand mux with constant slice bases.
   always_comb begin
      w_sel_dia = '0;
      w_sel_mes = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_gnt_id == ID_W'(k)) begin
            w_sel_dia = req_dia[k*DIA_W +: DIA_W];
            w_sel_mes = req_mes[k*MES_W +: MES_W];
         end
      end
   end

   // Ready is suppressed while reset is high because that edge drops the accept.
   assign req_ready = (r_state == IDLE && !reset && w_gnt_any)
                      ? (N_REQ'(1) << w_gnt_id) : '0;
   assign busy      = (r_state != IDLE);

   // Compares against the reference held during COMP, so a reference load in
   // the accept cycle is seen, while one during COMP is not.
   comparador_fecha_unit u_cmp (
      .i_dia     (r_dia),
      .i_mes     (r_mes),
      .i_dia_ref (r_ref_dia),
      .i_mes_ref (r_ref_mes),
      .o_v       (w_v)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_id       <= '0;
         r_dia      <= '0;
         r_mes      <= '0;
         r_ref_dia  <= DIA_W'(1);
         r_ref_mes  <= MES_W'(1);
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_V     <= V_MENOR;
      end else begin
         if (ref_we) begin
            r_ref_dia <= ref_dia;
            r_ref_mes <= ref_mes;
         end
         case (r_state)
            IDLE: begin
               if (w_gnt_any) begin
                  r_id    <= w_gnt_id;
                  r_dia   <= w_sel_dia;
                  r_mes   <= w_sel_mes;
                  r_state <= COMP;
               end
            end
            COMP: begin
               resp_V     <= w_v;
               resp_id    <= r_id;
               resp_valid <= 1'b1;
               r_state    <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_rr_ptr   <= ID_W'((int'(r_id) + 1) % N_REQ);
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ARBITRO_COMP_STATS_EN
   logic w_hs;
   assign w_hs = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_menor    <= '0;
         cnt_igual    <= '0;
         cnt_mayor    <= '0;
         cnt_invalido <= '0;
      end else if (w_hs) begin
         case (resp_V)
            V_MENOR: if (cnt_menor    != 16'hFFFF) cnt_menor    <= cnt_menor    + 16'd1;
            V_IGUAL: if (cnt_igual    != 16'hFFFF) cnt_igual    <= cnt_igual    + 16'd1;
            V_MAYOR: if (cnt_mayor    != 16'hFFFF) cnt_mayor    <= cnt_mayor    + 16'd1;
            default: if (cnt_invalido != 16'hFFFF) cnt_invalido <= cnt_invalido + 16'd1;
         endcase
      end
   end
`endif

endmodule
`default_nettype wire
